// File: rtl/miller_frame_sync.sv
// rtl/miller_frame_sync.sv - Modified Miller SoF/EoF framer and X/Y/Z symbol classifier for the 14443-A PCD->PICC path
module miller_frame_sync #(
    parameter int ETU_CLKS  = 32,
    parameter int CNT_W     = 6,
    parameter int TOL       = 3,
    parameter int PAUSE_MIN = 5,
    parameter int PAUSE_MAX = 12
) (
    input  logic       in_clk,
    input  logic       in_PoR,
    input  logic       in_rx_en,
    input  logic [1:0] in_rate,
    input  logic       in_pause,
    output logic       out_enable,
    output logic       out_sof,
    output logic       out_eof,
    output logic       out_sym_valid,
    output logic [1:0] out_symbol,
    output logic       out_bit,
    output logic       out_err
);

    typedef enum logic [1:0] {IDLE, SOF, FRAME} state_t;

    localparam logic [1:0]       SYM_Y    = 2'b00;
    localparam logic [1:0]       SYM_X    = 2'b01;
    localparam logic [1:0]       SYM_Z    = 2'b10;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PW_LIMIT = CNT_W'(PAUSE_MAX + 1);
    localparam logic [CNT_W-1:0] PW_MIN   = CNT_W'(PAUSE_MIN);
    localparam logic [CNT_W:0]   TOL_W    = (CNT_W + 1)'(TOL);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, etu, etu_nxt, pw;
    logic             p_d, enable, enable_nxt, seen, seen_nxt;
    logic [1:0]       kind, kind_nxt, prev, prev_nxt;

    logic             rise, fall, pw_bad, last, z_win, x_win;
    logic [CNT_W-1:0] half;
    logic [CNT_W:0]   cnt_w, half_w;

    logic             sof, eof, vld, dec_bit, err;
    logic [1:0]       sym;

    assign rise   = in_pause & ~p_d;
    assign fall   = ~in_pause & p_d;
    // Over-long pauses are flagged the cycle the width counter reaches the limit, not at the fall.
    assign pw_bad = (p_d && pw == PW_LIMIT) || (fall && pw < PW_MIN);
    assign half   = etu >> 1;
    assign last   = (cnt == etu - ONE);
    assign cnt_w  = {1'b0, cnt};
    assign half_w = {1'b0, half};
    assign z_win  = cnt_w <= TOL_W;
    assign x_win  = (cnt_w + TOL_W >= half_w) && (cnt_w <= half_w + TOL_W);

    always_ff @(posedge in_clk) begin
        if (in_PoR) begin
            state  <= IDLE;
            cnt    <= '0;
            etu    <= '0;
            pw     <= '0;
            p_d    <= 1'b0;
            enable <= 1'b0;
            seen   <= 1'b0;
            kind   <= SYM_Y;
            prev   <= SYM_Y;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            etu    <= etu_nxt;
            p_d    <= in_pause;
            enable <= enable_nxt;
            seen   <= seen_nxt;
            kind   <= kind_nxt;
            prev   <= prev_nxt;
            if (rise) begin
                pw <= ONE;
            end else if (in_pause && pw != '1) begin
                pw <= pw + ONE;
            end
        end
    end

    always_comb begin
        logic       cur_seen;
        logic [1:0] cur_kind;
        logic [1:0] cur_sym;
        logic       bad;
        state_nxt  = state;
        cnt_nxt    = cnt;
        etu_nxt    = etu;
        enable_nxt = enable;
        seen_nxt   = seen;
        kind_nxt   = kind;
        prev_nxt   = prev;
        sof        = 1'b0;
        eof        = 1'b0;
        vld        = 1'b0;
        sym        = SYM_Y;
        dec_bit    = 1'b0;
        err        = 1'b0;
        cur_seen   = seen;
        cur_kind   = kind;
        cur_sym    = SYM_Y;
        bad        = 1'b0;

        if (!in_rx_en) begin
            state_nxt  = IDLE;
            enable_nxt = 1'b0;
            cnt_nxt    = '0;
            seen_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    etu_nxt = CNT_W'(ETU_CLKS >> in_rate);
                    if (rise) begin
                        cnt_nxt   = ONE;
                        seen_nxt  = 1'b0;
                        state_nxt = SOF;
                    end
                end
                SOF: begin
                    if (rise || pw_bad) begin
                        bad = 1'b1;
                    end else if (last) begin
                        sof        = 1'b1;
                        enable_nxt = 1'b1;
                        prev_nxt   = SYM_Z;
                        cnt_nxt    = '0;
                        seen_nxt   = 1'b0;
                        state_nxt  = FRAME;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
                FRAME: begin
                    cnt_nxt = last ? '0 : cnt + ONE;
                    // A legal pause edge re-anchors the ETU counter to the nominal slot position.
                    if (rise) begin
                        if (seen) begin
                            bad = 1'b1;
                        end else if (z_win) begin
                            cur_seen = 1'b1;
                            cur_kind = SYM_Z;
                            cnt_nxt  = ONE;
                        end else if (x_win) begin
                            cur_seen = 1'b1;
                            cur_kind = SYM_X;
                            cnt_nxt  = half + ONE;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    if (pw_bad) begin
                        bad = 1'b1;
                    end
                    if (!bad && last) begin
                        cur_sym  = cur_seen ? cur_kind : SYM_Y;
                        seen_nxt = 1'b0;
                        if (cur_sym == SYM_Z && prev == SYM_X) begin
                            bad = 1'b1;
                        end else if (cur_sym == SYM_Y && prev != SYM_X) begin
                            eof        = 1'b1;
                            enable_nxt = 1'b0;
                            cnt_nxt    = '0;
                            state_nxt  = IDLE;
                        end else begin
                            vld      = 1'b1;
                            sym      = cur_sym;
                            dec_bit  = (cur_sym == SYM_X);
                            prev_nxt = cur_sym;
                        end
                    end else if (!bad) begin
                        seen_nxt = cur_seen;
                        kind_nxt = cur_kind;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (bad) begin
                err        = 1'b1;
                enable_nxt = 1'b0;
                cnt_nxt    = '0;
                seen_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
        end
    end

    assign out_enable    = enable;
    assign out_sof       = sof & ~in_PoR;
    assign out_eof       = eof & ~in_PoR;
    assign out_sym_valid = vld & ~in_PoR;
    assign out_symbol    = in_PoR ? 2'b00 : sym;
    assign out_bit       = dec_bit & ~in_PoR;
    assign out_err       = err & ~in_PoR;

endmodule

// File: tb/tb_miller_frame_sync.sv
// tb/tb_miller_frame_sync.sv - directed bench for miller_frame_sync at 106 and 848 kbit/s
module tb_miller_frame_sync;

    logic       clk = 1'b0;
    logic       por, pause, en_a, en_b;
    logic [1:0] rate_a, rate_b;
    logic       a_enable, a_sof, a_eof, a_vld, a_bit, a_err;
    logic       b_enable, b_sof, b_eof, b_vld, b_bit, b_err;
    logic [1:0] a_sym, b_sym;

    always #5 clk = ~clk;

    miller_frame_sync u_a (
        .in_clk(clk), .in_PoR(por), .in_rx_en(en_a), .in_rate(rate_a), .in_pause(pause),
        .out_enable(a_enable), .out_sof(a_sof), .out_eof(a_eof), .out_sym_valid(a_vld),
        .out_symbol(a_sym), .out_bit(a_bit), .out_err(a_err)
    );

    miller_frame_sync #(.ETU_CLKS(32), .CNT_W(6), .TOL(0), .PAUSE_MIN(1), .PAUSE_MAX(1)) u_b (
        .in_clk(clk), .in_PoR(por), .in_rx_en(en_b), .in_rate(rate_b), .in_pause(pause),
        .out_enable(b_enable), .out_sof(b_sof), .out_eof(b_eof), .out_sym_valid(b_vld),
        .out_symbol(b_sym), .out_bit(b_bit), .out_err(b_err)
    );

    int           checks = 0;
    int           errors = 0;
    bit           sel_b  = 1'b0;
    logic [255:0] p_pat, r_pat, e_pat;
    logic [255:0] sof_h, eof_h, err_h, vld_h, en_h, bit_h;
    logic [1:0]   sym_h [256];

    function automatic logic [255:0] span(input int s, input int e);
        logic [255:0] r;
        r = '0;
        for (int i = s; i <= e; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic clear_pat();
        p_pat = '0;
        r_pat = '0;
        e_pat = '1;
    endtask

    task automatic add_pause(input int s, input int l);
        for (int i = s; i < s + l; i++) p_pat[i] = 1'b1;
    endtask

    // Drive one cycle per pattern bit; outputs are captured on the falling edge.
    task automatic run(input int n);
        sof_h = '0; eof_h = '0; err_h = '0; vld_h = '0; en_h = '0; bit_h = '0;
        for (int i = 0; i < n; i++) begin
            pause = p_pat[i];
            por   = r_pat[i];
            en_a  = sel_b ? 1'b0 : e_pat[i];
            en_b  = sel_b ? e_pat[i] : 1'b0;
            @(negedge clk);
            sof_h[i] = sel_b ? b_sof    : a_sof;
            eof_h[i] = sel_b ? b_eof    : a_eof;
            err_h[i] = sel_b ? b_err    : a_err;
            vld_h[i] = sel_b ? b_vld    : a_vld;
            en_h[i]  = sel_b ? b_enable : a_enable;
            bit_h[i] = sel_b ? b_bit    : a_bit;
            sym_h[i] = sel_b ? b_sym    : a_sym;
            @(posedge clk);
            #1;
        end
        pause = 1'b0;
        por   = 1'b0;
    endtask

    task automatic idle();
        pause = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        por = 1'b1; pause = 1'b0; en_a = 1'b1; en_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a_enable, a_sof, a_eof, a_vld, a_sym, a_bit, a_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_a: got %b want 00000000", {a_enable, a_sof, a_eof, a_vld, a_sym, a_bit, a_err});
        end
        checks++;
        if ({b_enable, b_sof, b_eof, b_vld, b_sym, b_bit, b_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_b: got %b want 00000000", {b_enable, b_sof, b_eof, b_vld, b_sym, b_bit, b_err});
        end
        @(posedge clk); #1;
        por = 1'b0;
        idle();
    endtask

    task automatic test_basic_frame();
        clear_pat(); add_pause(0, 8); add_pause(48, 8);
        run(135);
        checks++; if (sof_h !== span(31, 31)) begin errors++; $display("FAIL basic_sof: got %h want %h", sof_h, span(31, 31)); end
        checks++; if (vld_h !== (span(63, 63) | span(95, 95))) begin errors++; $display("FAIL basic_vld: got %h", vld_h); end
        checks++; if (sym_h[63] !== 2'b01 || bit_h[63] !== 1'b1) begin errors++; $display("FAIL basic_x: got %b/%b want 01/1", sym_h[63], bit_h[63]); end
        checks++; if (sym_h[95] !== 2'b00 || bit_h[95] !== 1'b0) begin errors++; $display("FAIL basic_y: got %b/%b want 00/0", sym_h[95], bit_h[95]); end
        checks++; if (eof_h !== span(127, 127)) begin errors++; $display("FAIL basic_eof: got %h want %h", eof_h, span(127, 127)); end
        checks++; if (en_h !== span(32, 127)) begin errors++; $display("FAIL basic_enable: got %h want %h", en_h, span(32, 127)); end
        checks++; if (err_h !== '0) begin errors++; $display("FAIL basic_err: got %h want 0", err_h); end
        idle();
    endtask

    task automatic test_late_z();
        clear_pat(); add_pause(0, 8); add_pause(34, 8);
        run(105);
        checks++; if (vld_h !== span(65, 65)) begin errors++; $display("FAIL latez_vld: got %h want %h", vld_h, span(65, 65)); end
        checks++; if (sym_h[65] !== 2'b10 || bit_h[65] !== 1'b0) begin errors++; $display("FAIL latez_sym: got %b/%b want 10/0", sym_h[65], bit_h[65]); end
        checks++; if (eof_h !== span(97, 97)) begin errors++; $display("FAIL latez_eof: got %h want %h", eof_h, span(97, 97)); end
        checks++; if (en_h !== span(32, 97)) begin errors++; $display("FAIL latez_enable: got %h want %h", en_h, span(32, 97)); end
        idle();
    endtask

    task automatic test_pause_width();
        clear_pat(); add_pause(0, 3);
        run(40);
        checks++; if (err_h !== span(3, 3)) begin errors++; $display("FAIL short_err: got %h want %h", err_h, span(3, 3)); end
        checks++; if ((sof_h | eof_h | en_h) !== '0) begin errors++; $display("FAIL short_nosof: got %h want 0", sof_h | eof_h | en_h); end
        idle();
        clear_pat(); add_pause(0, 8); add_pause(48, 14);
        run(100);
        checks++; if (err_h !== span(61, 61)) begin errors++; $display("FAIL long_err: got %h want %h", err_h, span(61, 61)); end
        checks++; if ((eof_h | vld_h) !== '0) begin errors++; $display("FAIL long_noeof: got %h want 0", eof_h | vld_h); end
        checks++; if (en_h !== span(32, 61)) begin errors++; $display("FAIL long_enable: got %h want %h", en_h, span(32, 61)); end
        idle();
    endtask

    task automatic test_offset_window();
        clear_pat(); add_pause(0, 8); add_pause(41, 8);
        run(80);
        checks++; if (err_h !== span(41, 41)) begin errors++; $display("FAIL window_err: got %h want %h", err_h, span(41, 41)); end
        checks++; if (en_h !== span(32, 41)) begin errors++; $display("FAIL window_enable: got %h want %h", en_h, span(32, 41)); end
        idle();
    endtask

    task automatic test_illegal_seq();
        clear_pat(); add_pause(0, 8); add_pause(48, 8); add_pause(64, 8);
        run(110);
        checks++; if (err_h !== span(95, 95)) begin errors++; $display("FAIL zafterx_err: got %h want %h", err_h, span(95, 95)); end
        checks++; if (vld_h !== span(63, 63) || eof_h !== '0) begin errors++; $display("FAIL zafterx_vld: got %h want %h", vld_h, span(63, 63)); end
        idle();
    endtask

    task automatic test_fast_rate();
        sel_b = 1'b1;
        clear_pat(); add_pause(0, 1); add_pause(6, 1);
        run(22);
        checks++; if (sof_h !== span(3, 3)) begin errors++; $display("FAIL fast_sof: got %h want %h", sof_h, span(3, 3)); end
        checks++; if (vld_h !== (span(7, 7) | span(11, 11))) begin errors++; $display("FAIL fast_vld: got %h", vld_h); end
        checks++; if (sym_h[7] !== 2'b01 || sym_h[11] !== 2'b00 || bit_h !== span(7, 7)) begin
            errors++; $display("FAIL fast_sym: got %b %b bits %h want 01 00", sym_h[7], sym_h[11], bit_h);
        end
        checks++; if (eof_h !== span(15, 15) || err_h !== '0) begin errors++; $display("FAIL fast_eof: got %h want %h", eof_h, span(15, 15)); end
        sel_b = 1'b0;
        idle();
    endtask

    task automatic test_reset_midframe();
        clear_pat(); add_pause(0, 8); r_pat[40] = 1'b1; add_pause(50, 8);
        run(90);
        checks++; if (en_h !== (span(32, 40) | span(82, 89))) begin errors++; $display("FAIL por_enable: got %h", en_h); end
        checks++; if ((err_h | eof_h | vld_h | bit_h) !== '0) begin errors++; $display("FAIL por_quiet: got %h want 0", err_h | eof_h | vld_h | bit_h); end
        checks++; if (sof_h !== (span(31, 31) | span(81, 81))) begin errors++; $display("FAIL por_resof: got %h", sof_h); end
        idle();
    endtask

    task automatic test_rx_disabled();
        clear_pat(); add_pause(0, 8);
        for (int i = 0; i < 4; i++) e_pat[i] = 1'b0;
        run(45);
        checks++; if ((sof_h | en_h | err_h) !== '0) begin errors++; $display("FAIL rxen_nosof: got %h want 0", sof_h | en_h | err_h); end
        idle();
    endtask

    initial begin
        rate_a = 2'd0;
        rate_b = 2'd3;
        test_reset();
        test_basic_frame();
        test_late_z();
        test_pause_width();
        test_offset_window();
        test_illegal_seq();
        test_fast_rate();
        test_reset_midframe();
        test_rx_disabled();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
